// File: rtl/key_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_sched_pkg
//  Purpose  : Shared constants, FSM state type and the GF(2^8) xtime helper
//             for the key schedule engine.
//  Revision : 1.0 - initial release
// ============================================================================
package key_sched_pkg;

  localparam int         KEY_W     = 64;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Multiply by x in GF(2^8); a non-zero input never maps to zero.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/NextKey.sv
`default_nettype none
// ============================================================================
//  Module   : NextKey
//  Purpose  : Combinational Simplified-AES round-key function. The key is
//             four 16-bit words w0..w3 (w0 most significant):
//               t   = SubNib(RotWord(w3))   (byte swap, then 4-bit S-box)
//               w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
//  Revision : 1.0 - initial release
// ============================================================================
module NextKey
  import key_sched_pkg::*;
(
  input  logic [KEY_W-1:0] curKey,
  output logic [KEY_W-1:0] nextKey
);

  // S-AES nibble substitution box
  function automatic logic [3:0] sBox(input logic [3:0] n);
    case (n)
      4'h0: sBox = 4'h9;  4'h1: sBox = 4'h4;  4'h2: sBox = 4'hA;  4'h3: sBox = 4'hB;
      4'h4: sBox = 4'hD;  4'h5: sBox = 4'h1;  4'h6: sBox = 4'h8;  4'h7: sBox = 4'h5;
      4'h8: sBox = 4'h6;  4'h9: sBox = 4'h2;  4'hA: sBox = 4'h0;  4'hB: sBox = 4'h3;
      4'hC: sBox = 4'hC;  4'hD: sBox = 4'hE;  4'hE: sBox = 4'hF;  default: sBox = 4'h7;
    endcase
  endfunction

  logic [15:0] w_w0, w_w1, w_w2, w_w3;
  logic [15:0] w_rot, w_sub;
  logic [15:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = curKey;
  assign w_rot = {w_w3[7:0], w_w3[15:8]};
  assign w_sub = {sBox(w_rot[15:12]), sBox(w_rot[11:8]), sBox(w_rot[7:4]), sBox(w_rot[3:0])};
  assign w_n0  = w_w0 ^ w_sub;
  assign w_n1  = w_w1 ^ w_n0;
  assign w_n2  = w_w2 ^ w_n1;
  assign w_n3  = w_w3 ^ w_n2;
  assign nextKey = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/key_schedule_engine.sv
`default_nettype none
// ============================================================================
//  Module   : key_schedule_engine
//  Purpose  : Sequential S-AES key expansion. One NextKey round per clock,
//             every round key kept in an internal buffer, registered read
//             port with validity tracking, start/busy/done handshake.
//  Options  : KEY_SCHED_RCON_EN - XOR a per-round constant (rcon, advanced
//             by xtime each round) into the top byte of every round key.
//  Revision : 1.0 - initial release
// ============================================================================
module key_schedule_engine
  import key_sched_pkg::*;
#(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] RCON_INIT  = 8'h01,
  localparam int        AW         = $clog2(NUM_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] master_key,
  output logic             busy,
  output logic             done,
  input  logic [AW-1:0]    rd_addr,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid
);

  // Valid count runs to NUM_ROUNDS+1, which may need one bit more than AW.
  localparam int CW = $clog2(NUM_ROUNDS + 2);

  state_t           r_state;
  logic [AW-1:0]    r_round;
  logic [CW-1:0]    r_validCount;
  logic [KEY_W-1:0] r_workKey;
  logic [KEY_W-1:0] r_buf [0:NUM_ROUNDS];

  logic [KEY_W-1:0] w_nextKey;
  logic [KEY_W-1:0] w_roundKey;
  logic             w_accept;
  logic             w_wrEn;
  logic [AW-1:0]    w_wrAddr;
  logic [KEY_W-1:0] w_wrData;
  logic             w_rdInRange;

  NextKey uNextKey (
    .curKey  (r_workKey),
    .nextKey (w_nextKey)
  );

`ifdef KEY_SCHED_RCON_EN
  logic [7:0] r_rcon;

  assign w_roundKey = w_nextKey ^ {r_rcon, {(KEY_W-8){1'b0}}};

  // Round constant: seeded on an accepted start, advanced once per round
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcon <= RCON_INIT;
    end else if (w_accept) begin
      r_rcon <= RCON_INIT;
    end else if (r_state == ST_EXPAND) begin
      r_rcon <= xtime(r_rcon);
    end
  end
`else
  logic w_unusedRconInit;

  assign w_roundKey       = w_nextKey;
  assign w_unusedRconInit = ^RCON_INIT;
`endif

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_wrEn      = w_accept || (r_state == ST_EXPAND);
  assign w_wrAddr    = w_accept ? '0 : r_round;
  assign w_wrData    = w_accept ? master_key : w_roundKey;
  assign w_rdInRange = (rd_addr <= AW'(NUM_ROUNDS));

  // Control FSM with registered busy/done; done trails the DONE state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_round      <= '0;
      r_validCount <= '0;
      r_workKey    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_workKey    <= master_key;
            r_validCount <= CW'(1);
            r_round      <= AW'(1);
            busy         <= 1'b1;
            r_state      <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          r_workKey    <= w_roundKey;
          r_validCount <= CW'(r_round) + CW'(1);
          if (r_round == AW'(NUM_ROUNDS)) begin
            r_state <= ST_DONE;
          end else begin
            r_round <= r_round + AW'(1);
          end
        end
        ST_DONE: begin
          r_round <= '0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Key buffer: never cleared, only invalidated through the valid count
  always_ff @(posedge clk) begin
    if (!rst && w_wrEn) begin
      r_buf[w_wrAddr] <= w_wrData;
    end
  end

  // Registered read port; sees the buffer and valid count from before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_key   <= w_rdInRange ? r_buf[rd_addr] : '0;
      rd_valid <= (CW'(rd_addr) < r_validCount);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_schedule_engine
//  Purpose  : Self-checking bench for key_schedule_engine (NUM_ROUNDS=10).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_schedule_engine;

  localparam int N  = 10;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [63:0]   masterKey;
  logic          busy;
  logic          done;
  logic [AW-1:0] rdAddr;
  logic [63:0]   rdKey;
  logic          rdValid;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  key_schedule_engine #(.NUM_ROUNDS(N), .RCON_INIT(8'h01)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .master_key (masterKey),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rdAddr),
    .rd_key     (rdKey),
    .rd_valid   (rdValid)
  );

  // ---------------- reference model ----------------
  int sboxTab [16] = '{9, 4, 10, 11, 13, 1, 8, 5, 6, 2, 0, 3, 12, 14, 15, 7};
`ifdef KEY_SCHED_RCON_EN
  int rconTab [N+1] = '{0, 'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80, 'h1B, 'h36};
`else
  int rconTab [N+1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

  function automatic logic [63:0] mNextKey(input logic [63:0] k);
    int w [4];
    int rot, sub;
    for (int i = 0; i < 4; i++) w[i] = int'((k >> (48 - 16*i)) & 64'hFFFF);
    rot = ((w[3] * 256) + (w[3] / 256)) % 65536;
    sub = 0;
    for (int j = 3; j >= 0; j--) sub = sub * 16 + sboxTab[(rot >> (4*j)) % 16];
    w[0] = w[0] ^ sub;
    for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
    return {w[0][15:0], w[1][15:0], w[2][15:0], w[3][15:0]};
  endfunction

  function automatic logic [63:0] mRoundKey(input logic [63:0] mk, input int r);
    logic [63:0] k = mk;
    logic [7:0]  rc;
    for (int i = 1; i <= r; i++) begin
      rc = rconTab[i][7:0];
      k  = mNextKey(k) ^ {rc, 56'h0};
    end
    return k;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doStart(input logic [63:0] key);
    start     = 1'b1;
    masterKey = key;
    tick();
    start     = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen (bounded)
  task automatic waitDone(input int from, output int edges);
    edges = from;
    while (done !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; masterKey = '0; rdAddr = '0;
    tick(); tick();
    rst = 1'b0;
    nChecks++; if (busy !== 1'b0)    begin nFails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nChecks++; if (done !== 1'b0)    begin nFails++; $display("FAIL reset_done: got %b expected 0", done); end
    nChecks++; if (rdValid !== 1'b0) begin nFails++; $display("FAIL reset_rd_valid: got %b expected 0", rdValid); end
    nChecks++; if (rdKey !== 64'h0)  begin nFails++; $display("FAIL reset_rd_key: got %h expected 0", rdKey); end
  endtask

  task automatic test_basic;
    logic [63:0] mk = 64'h123456789ABCDEF0;
    int edges;
    doStart(mk);
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL basic_busy: got %b expected 1", busy); end
    waitDone(0, edges);
    nChecks++; if (edges != N+1) begin nFails++; $display("FAIL basic_done_latency: got %0d expected %0d", edges, N+1); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    tick();
    nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    for (int a = 0; a <= N; a++) begin
      rdAddr = AW'(a);
      tick();
      nChecks++;
      if (rdKey !== mRoundKey(mk, a) || rdValid !== 1'b1) begin
        nFails++;
        $display("FAIL basic_read[%0d]: got %h/%b expected %h/1", a, rdKey, rdValid, mRoundKey(mk, a));
      end
    end
  endtask

  task automatic test_progressive;
    logic [63:0] mk = 64'hFEDCBA9876543210;
    int edges;
    rdAddr = AW'(3);
    doStart(mk);
    for (int k = 1; k <= N; k++) begin
      tick();
      nChecks++;
      if (rdValid !== (k > 4 - 1 + 0 && 3 < k)) begin
        nFails++;
        $display("FAIL progressive_valid[edge %0d]: got %b expected %b", k, rdValid, (3 < k));
      end
      if (3 < k) begin
        nChecks++;
        if (rdKey !== mRoundKey(mk, 3)) begin
          nFails++;
          $display("FAIL progressive_key[edge %0d]: got %h expected %h", k, rdKey, mRoundKey(mk, 3));
        end
      end
    end
    rdAddr = AW'(11);
    for (int k = 0; k < 3; k++) begin
      tick();
      nChecks++;
      if (rdValid !== 1'b0 || rdKey !== 64'h0) begin
        nFails++;
        $display("FAIL out_of_range_read: got %h/%b expected 0/0", rdKey, rdValid);
      end
    end
    waitDone(N+3, edges);
    tick();
  endtask

  task automatic test_busy_ignore;
    logic [63:0] mk = 64'hCAFEBABEDEADC0DE;
    int edges;
    doStart(mk);
    tick(); tick(); tick();
    start = 1'b1; masterKey = 64'h0;
    tick();
    start = 1'b0;
    waitDone(4, edges);
    nChecks++; if (edges != N+1) begin nFails++; $display("FAIL busy_ignore_latency: got %0d expected %0d", edges, N+1); end
    tick();
    for (int a = 0; a <= N; a += 5) begin
      rdAddr = AW'(a);
      tick();
      nChecks++;
      if (rdKey !== mRoundKey(mk, a) || rdValid !== 1'b1) begin
        nFails++;
        $display("FAIL busy_ignore_read[%0d]: got %h/%b expected %h/1", a, rdKey, rdValid, mRoundKey(mk, a));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] mk = 64'h0102030405060708;
    int edges;
    bit doneSeen = 0;
    rdAddr = '0;
    doStart(mk);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nChecks++; if (busy !== 1'b0)    begin nFails++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
    nChecks++; if (rdValid !== 1'b0) begin nFails++; $display("FAIL reset_mid_valid: got %b expected 0", rdValid); end
    tick();
    nChecks++; if (rdValid !== 1'b0) begin nFails++; $display("FAIL reset_mid_valid_after: got %b expected 0", rdValid); end
    for (int k = 0; k < N+4; k++) begin
      if (done === 1'b1) doneSeen = 1;
      tick();
    end
    nChecks++; if (doneSeen) begin nFails++; $display("FAIL reset_mid_no_done: got 1 expected 0"); end
    doStart(mk);
    waitDone(0, edges);
    nChecks++; if (edges != N+1) begin nFails++; $display("FAIL reset_mid_restart_latency: got %0d expected %0d", edges, N+1); end
    rdAddr = AW'(N);
    tick();
    nChecks++;
    if (rdKey !== mRoundKey(mk, N) || rdValid !== 1'b1) begin
      nFails++;
      $display("FAIL reset_mid_restart_read: got %h/%b expected %h/1", rdKey, rdValid, mRoundKey(mk, N));
    end
  endtask

  task automatic test_rcon_chain;
    logic [63:0] prev, cur;
    logic [7:0]  rc;
    int edges;
    doStart(64'h0);
    waitDone(0, edges);
    tick();
    rdAddr = '0;
    tick();
    prev = rdKey;
    nChecks++; if (prev !== 64'h0) begin nFails++; $display("FAIL rcon_slot0: got %h expected 0", prev); end
    for (int r = 1; r <= N; r++) begin
      rdAddr = AW'(r);
      tick();
      cur = rdKey;
      rc  = rconTab[r][7:0];
      nChecks++;
      if (cur !== (mNextKey(prev) ^ {rc, 56'h0})) begin
        nFails++;
        $display("FAIL rcon_chain[%0d]: got %h expected %h", r, cur, mNextKey(prev) ^ {rc, 56'h0});
      end
      prev = cur;
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] k1 = 64'h1122334455667788;
    logic [63:0] k2 = 64'h8877665544332211;
    int edges;
    doStart(k1);
    waitDone(0, edges);
    rdAddr = AW'(1);
    doStart(k2);
    nChecks++;
    if (rdValid !== 1'b1 || rdKey !== mRoundKey(k1, 1)) begin
      nFails++;
      $display("FAIL b2b_old_slot1: got %h/%b expected %h/1", rdKey, rdValid, mRoundKey(k1, 1));
    end
    tick();
    nChecks++; if (rdValid !== 1'b0) begin nFails++; $display("FAIL b2b_slot1_invalid: got %b expected 0", rdValid); end
    waitDone(1, edges);
    nChecks++; if (edges != N+1) begin nFails++; $display("FAIL b2b_latency: got %0d expected %0d", edges, N+1); end
    for (int a = 0; a <= N; a++) begin
      rdAddr = AW'(a);
      tick();
      nChecks++;
      if (rdKey !== mRoundKey(k2, a) || rdValid !== 1'b1) begin
        nFails++;
        $display("FAIL b2b_read[%0d]: got %h/%b expected %h/1", a, rdKey, rdValid, mRoundKey(k2, a));
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] mk;
    int addr, pre;
    for (int it = 0; it < 4; it++) begin
      mk = {$urandom, $urandom};
      doStart(mk);
      for (int k = 1; k <= N+1; k++) begin
        addr   = $urandom_range(0, 15);
        rdAddr = AW'(addr);
        tick();
        pre = (k < N+1) ? k : N+1;
        nChecks++;
        if (rdValid !== (addr < pre)) begin
          nFails++;
          $display("FAIL random_valid[it %0d edge %0d addr %0d]: got %b expected %b", it, k, addr, rdValid, (addr < pre));
        end
        if (addr > N) begin
          nChecks++;
          if (rdKey !== 64'h0) begin nFails++; $display("FAIL random_oor_key[addr %0d]: got %h expected 0", addr, rdKey); end
        end else if (addr < pre) begin
          nChecks++;
          if (rdKey !== mRoundKey(mk, addr)) begin
            nFails++;
            $display("FAIL random_key[it %0d addr %0d]: got %h expected %h", it, addr, rdKey, mRoundKey(mk, addr));
          end
        end
      end
      nChecks++; if (done !== 1'b1) begin nFails++; $display("FAIL random_done[it %0d]: got %b expected 1", it, done); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_progressive();
    test_busy_ignore();
    test_reset_mid();
    test_rcon_chain();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_schedule_engine.md
Name: key_schedule_engine

Overview:
- Sequential key-expansion engine for the Simplified-AES datapath.
- Takes a 64-bit master key and iterates the existing combinational NextKey round function once per clock, for NUM_ROUNDS rounds.
- Stores every round key (index 0 = master key) in an internal buffer.
- The cipher core reads stored keys through a registered read port; start/busy/done handshake to the controller.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; buffer holds NUM_ROUNDS+1 keys; legal range 1..64.
- RCON_INIT, 8'h01, first round constant; used only when KEY_SCHED_RCON_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request expansion of master_key; sampled only in IDLE.
- master_key  input  64  key captured on accepted start.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when the full schedule is valid.
- rd_addr  input  AW=$clog2(NUM_ROUNDS+1)  round-key index to read.
- rd_key  output  64  registered round key for rd_addr.
- rd_valid  output  1  registered; high when rd_key holds a valid key.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, rd_key=0, rd_valid=0, state=IDLE, round counter=0, valid-count=0. The key buffer is not cleared, only invalidated.
- FSM IDLE:
  - start=1 → write master_key to slot 0, set valid-count=1, load working register and rcon=RCON_INIT, go to EXPAND.
  - start=0 → stay.
- FSM EXPAND, each cycle r = 1..NUM_ROUNDS:
  - Compute key[r] = NextKey(key[r-1]) (RCON variant below).
  - Write slot r, update working register, valid-count=r+1.
  - After r=NUM_ROUNDS → DONE.
- FSM DONE: assert done for exactly one cycle, then → IDLE.
- busy is high in EXPAND and DONE, low in IDLE.
- Latency: start accepted at cycle T → slot r written at T+r → done high at T+NUM_ROUNDS+1.
- start while busy is ignored; no queueing.
- start in IDLE after a completed schedule:
  - Restarts expansion and resets valid-count to 1.
  - Old keys in slots ≥1 become invalid immediately.
- Read port (1-cycle latency): at each edge,
  - rd_key <= buffer[rd_addr].
  - rd_valid <= (rd_addr < valid-count).
- Out-of-range rd_addr (> NUM_ROUNDS): rd_key=0, rd_valid=0.
- Read and write of the same slot in the same cycle: returns the old buffer value, and rd_valid is based on the pre-write valid-count. The key is therefore invalid until the following cycle.
- Reset mid-EXPAND: the next cycle is IDLE with busy=0 and valid-count=0; no done pulse.
- Arithmetic: keys are a fixed 64 bits. rcon is 8 bits; each round rcon <= xtime(rcon), i.e. shift left one bit and XOR 8'h1B if the MSB was set. It wraps through GF(2^8) and never becomes 0.

Optional Feature:
- Macro: KEY_SCHED_RCON_EN.
- Defined: key[r] = NextKey(key[r-1]) XOR {rcon, 56'h0}, where rcon is the value for round r (round 1 uses RCON_INIT).
- Undefined: key[r] = NextKey(key[r-1]) exactly; the rcon register and logic are absent; RCON_INIT is unused.
- Handshake and timing are identical in both builds.

Decomposition:
- Package key_sched_pkg:
  - localparam KEY_W=64.
  - localparam RCON_POLY=8'h1B.
  - function xtime(8-bit).
  - enum-style state constants ST_IDLE, ST_EXPAND, ST_DONE.
- Round datapath: instantiate the existing NextKey module once, combinational, on the working register. No new sub-module.
- Buffer is an internal register array of NUM_ROUNDS+1 x 64.

Test Plan:
- Basic expansion:
  - Stimulus: NUM_ROUNDS=10, rst then start with master_key=64'h123456789ABCDEF0.
  - Response: done pulses exactly 11 cycles after start.
  - Reading addresses 0..10 gives addr 0 = 64'h123456789ABCDEF0, and each addr r = NextKey bench model applied r times; rd_valid=1 for all.
- Progressive valid:
  - Stimulus: start with 64'hFEDCBA9876543210, then poll rd_addr=3 every cycle.
  - Response: rd_valid goes 0→1 on the edge after T+3; rd_addr=11 always returns rd_valid=0 and rd_key=0.
- Busy-ignore:
  - Stimulus: start with 64'hCAFEBABEDEADC0DE; pulse start with 64'h0 at T+4.
  - Response: schedule is unaffected, done at T+11, slot 0 still CAFEBABEDEADC0DE.
- Reset mid-run:
  - Stimulus: assert rst at T+5 during expansion of 64'h0102030405060708.
  - Response: next cycle busy=0, rd_valid=0 for addr 0; no done pulse; a subsequent start completes normally.
- RCON build:
  - Stimulus: define KEY_SCHED_RCON_EN, master_key=64'h0, NUM_ROUNDS=10.
  - Response: slot 1 = NextKey(0) XOR 64'h0100000000000000.
  - rcon sequence over the 10 rounds is 01,02,04,08,10,20,40,80,1B,36.
- Back-to-back restart:
  - Stimulus: start with 64'h1122334455667788, wait for done, and in the next IDLE cycle start with 64'h8877665544332211.
  - Response: slot 1 reads invalid in the cycle after the second start; final schedule matches the model for the second key.
